// File: rtl/rv_serial_pkg.sv
// Shared types and helpers for the serial receive path.
package rv_serial_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_PARITY} rv_rx_state_t;

  // Widest word even_parity accepts; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned MaxParityWidth = 64;

  function automatic logic even_parity(input logic [MaxParityWidth-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rv_shift_receiver.sv
// MSB-first serial-to-parallel receiver with a single valid/ready holding register.
// Define RV_SHIFT_RECEIVER_PARITY_EN to expect a trailing even-parity bit per word.
module rv_shift_receiver
  import rv_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_error,
  input  logic             clear_status
);

  localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(WIDTH - 1);

`ifdef RV_SHIFT_RECEIVER_PARITY_EN
  // The whole word must be held while its parity bit arrives.
  localparam int unsigned SrWidth = WIDTH;
`else
  // The final bit goes straight to the holding register, so one fewer bit is stored.
  localparam int unsigned SrWidth = WIDTH - 1;
`endif

  rv_rx_state_t         state_q, state_d;
  logic [SrWidth-1:0]   sr_q, sr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
  logic                 perr_set;
  logic [WIDTH-1:0]     word;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    deliver  = 1'b0;
    perr_set = 1'b0;
    word     = WIDTH'({sr_q, bit_in});

    if (!frame) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        RX_IDLE, RX_SHIFT: begin
          state_d = RX_SHIFT;
          if (bit_valid) begin
            sr_d = SrWidth'({sr_q, bit_in});
            if (cnt_q == LastBit) begin
              cnt_d = '0;
`ifdef RV_SHIFT_RECEIVER_PARITY_EN
              state_d = RX_PARITY;
`else
              deliver = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
`ifdef RV_SHIFT_RECEIVER_PARITY_EN
        RX_PARITY: begin
          word = WIDTH'(sr_q);
          if (bit_valid) begin
            state_d = RX_SHIFT;
            if (even_parity(MaxParityWidth'(sr_q)) == bit_in) begin
              deliver = 1'b1;
            end else begin
              perr_set = 1'b1;
            end
          end
        end
`endif
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Holding register: a completed word may replace data only if the slot drains this cycle.
  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    if (deliver) begin
      if (!data_valid_q || data_ready) begin
        data_d       = word;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
    if (clear_status) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef RV_SHIFT_RECEIVER_PARITY_EN
  logic parity_error_q, parity_error_d;

  always_comb begin
    parity_error_d = parity_error_q | perr_set;
    if (clear_status) parity_error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_error_q <= 1'b0;
    else        parity_error_q <= parity_error_d;
  end

  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_rv_shift_receiver.sv
// Randomized bench for rv_shift_receiver against a bit-queue reference model.
module tb_rv_shift_receiver;

  localparam int unsigned W = 8;
`ifdef RV_SHIFT_RECEIVER_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame = 1'b0;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic [W-1:0] data;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         parity_error;
  logic         clear_status = 1'b0;

  rv_shift_receiver #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame        (frame),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .busy         (busy),
    .overrun      (overrun),
    .parity_error (parity_error),
    .clear_status (clear_status)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: received bits collect in a queue; a full queue is one word.
  bit           m_bits[$];
  bit           m_busy, m_par, m_valid, m_ovr, m_perr;
  logic [W-1:0] m_word, m_data;

  task automatic model_reset();
    m_bits.delete();
    m_busy = 0; m_par = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
    m_word = '0; m_data = '0;
  endtask

  task automatic step();
    logic [W-1:0] w;
    bit dlv, pe, ov;
    dlv = 0; pe = 0; ov = 0; w = '0;
    if (!frame) begin
      m_bits.delete();
      m_par  = 0;
      m_busy = 0;
    end else begin
      m_busy = 1;
      if (bit_valid) begin
        if (m_par) begin
          m_par = 0;
          if ((^m_word) == bit_in) begin dlv = 1; w = m_word; end
          else pe = 1;
        end else begin
          m_bits.push_back(bit_in);
          if (m_bits.size() == W) begin
            foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
            m_bits.delete();
            if (ParEn) begin m_par = 1; m_word = w; end
            else dlv = 1;
          end
        end
      end
    end
    if (dlv) begin
      if (!m_valid || data_ready) begin m_data = w; m_valid = 1; end
      else ov = 1;
    end else if (m_valid && data_ready) begin
      m_valid = 0;
    end
    if (clear_status) begin m_ovr = 0; m_perr = 0; end
    else begin m_ovr = m_ovr | ov; m_perr = m_perr | pe; end

    @(posedge clk);
    #1;
    check_val("data", 32'(data), 32'(m_data));
    check_val("data_valid", 32'(data_valid), 32'(m_valid));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
    check_val("parity_error", 32'(parity_error), 32'(m_perr));
  endtask

  task automatic drive(input bit f, input bit bv, input bit bi, input bit rdy, input bit clr);
    frame = f; bit_valid = bv; bit_in = bi; data_ready = rdy; clear_status = clr;
  endtask

  function automatic bit pick_ready(input int mode);
    return (mode == 2) ? bit'($urandom_range(1, 0)) : bit'(mode);
  endfunction

  // rlast < 0 keeps rmode on the final strobe; otherwise forces data_ready to rlast there.
  task automatic send_word(input logic [W-1:0] w, input int max_gap, input int rmode,
                           input int rlast, input bit par_bad);
    int nb;
    bit b;
    nb = ParEn ? W + 1 : W;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        drive(1, 0, bit'($urandom_range(1, 0)), pick_ready(rmode), 0);
        step();
      end
      b = (i < W) ? w[W-1-i] : ((^w) ^ par_bad);
      drive(1, 1, b, (i == nb - 1 && rlast >= 0) ? bit'(rlast) : pick_ready(rmode), 0);
      step();
    end
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, w[W-1-i], 0, 0);
      step();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_data", 32'(data), 0);
    check_val("rst_valid", 32'(data_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // 1: reset mid-word clears a held word and the partial one
    send_word(8'h96, 0, 0, -1, 0);
    send_bits(8'h5A, 3);
    rst_n = 1'b0;
    #1;
    check_val("t1_rst_data", 32'(data), 0);
    check_val("t1_rst_valid", 32'(data_valid), 0);
    check_val("t1_rst_busy", 32'(busy), 0);
    check_val("t1_rst_ovr", 32'(overrun), 0);
    model_reset();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h5A, 0, 0, -1, 0);
    check_val("t1_data", 32'(data), 32'h5A);
    check_val("t1_valid", 32'(data_valid), 1);

    // 2: back-to-back bits with ready high
    send_word(8'hA5, 0, 1, -1, 0);
    check_val("t2_data", 32'(data), 32'hA5);
    check_val("t2_valid", 32'(data_valid), 1);
    drive(1, 0, 0, 1, 0);
    step();
    check_val("t2_consumed", 32'(data_valid), 0);

    // 3: overrun while the slot is full, then drain and clear
    send_word(8'h11, 0, 0, -1, 0);
    send_word(8'h22, 0, 0, -1, 0);
    check_val("t3_data", 32'(data), 32'h11);
    check_val("t3_ovr", 32'(overrun), 1);
    drive(1, 0, 0, 1, 0);
    step();
    check_val("t3_drained", 32'(data_valid), 0);
    drive(1, 0, 0, 0, 1);
    step();
    check_val("t3_cleared", 32'(overrun), 0);

    // 4: delivery coincides with consumption of the held word
    send_word(8'h33, 0, 0, -1, 0);
    send_word(8'h44, 0, 0, 1, 0);
    check_val("t4_data", 32'(data), 32'h44);
    check_val("t4_valid", 32'(data_valid), 1);
    check_val("t4_ovr", 32'(overrun), 0);
    drive(1, 0, 0, 1, 0);
    step();

    // 5: abort a partial word, then receive with and without gaps
    send_bits(8'hFF, 3);
    drive(0, 1, 1, 0, 0);
    step();
    check_val("t5_busy", 32'(busy), 0);
    check_val("t5_valid", 32'(data_valid), 0);
    send_word(8'h3C, 0, 0, -1, 0);
    check_val("t5_data", 32'(data), 32'h3C);
    drive(1, 0, 0, 1, 0);
    step();
    send_word(8'h3C, 5, 1, -1, 0);
    check_val("t5_gap_data", 32'(data), 32'h3C);
    check_val("t5_gap_valid", 32'(data_valid), 1);
    drive(1, 0, 0, 1, 0);
    step();

`ifdef RV_SHIFT_RECEIVER_PARITY_EN
    // 6: parity good, bad, then good again
    send_word(8'hA5, 0, 1, -1, 0);
    check_val("t6_good", 32'(data), 32'hA5);
    drive(1, 0, 0, 1, 0);
    step();
    send_word(8'hA5, 0, 1, -1, 1);
    check_val("t6_bad_valid", 32'(data_valid), 0);
    check_val("t6_perr", 32'(parity_error), 1);
    send_word(8'h01, 0, 1, -1, 0);
    check_val("t6_next", 32'(data), 32'h01);
    check_val("t6_next_valid", 32'(data_valid), 1);
`endif

    // Random mix of words, gaps, consumer stalls, aborts and status clears
    for (int n = 0; n < 80; n++) begin
      int act;
      act = int'($urandom_range(9, 0));
      if (act == 0) begin
        send_bits(W'($urandom), int'($urandom_range(W - 1, 1)));
        drive(0, bit'($urandom_range(1, 0)), 1, pick_ready(2), 0);
        step();
      end else if (act == 1) begin
        drive(bit'($urandom_range(1, 0)), 0, 0, pick_ready(2), 1);
        step();
      end else begin
        send_word(W'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), -1,
                  ($urandom_range(7, 0) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
